// File: rtl/vid_pkg.sv
// Shared constants, control codes and state encoding for the video write scheduler.
package vid_pkg;

    localparam int COLS    = 80;
    localparam int ROWS    = 30;
    localparam int CELLS   = COLS * ROWS;
    localparam int VM_AW   = 12;
    localparam int COL_W   = 7;
    localparam int ROW_W   = 5;

    localparam logic [7:0] CH_LF = 8'h0A;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_BS = 8'h08;
    localparam logic [7:0] CH_FF = 8'h0C;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

    // Linear cell address row*COLS+col; the 80-column case is two shifts and an add.
    function automatic logic [VM_AW-1:0] cell_addr(input logic [ROW_W-1:0] row,
                                                   input logic [COL_W-1:0] col);
        logic [VM_AW-1:0] base;
        if (COLS == 80) begin
            base = (VM_AW'(row) << 6) + (VM_AW'(row) << 4);
        end else begin
            base = VM_AW'(int'(row) * COLS);
        end
        return base + VM_AW'(col);
    endfunction

endpackage

// File: rtl/vid_write_scheduler_if.sv
// Requester, timing and video-memory signals of the write scheduler.
interface vid_write_scheduler_if
    import vid_pkg::*;
();
    logic             wr_valid;
    logic [7:0]       wr_ch;
    logic             wr_ready;
    logic             blank;
    logic             vm_we;
    logic [VM_AW-1:0] vm_addr;
    logic [7:0]       vm_ch;
    logic [COL_W-1:0] cur_col;
    logic [ROW_W-1:0] cur_row;
    logic             busy;

    // Scheduler side.
    modport slave (
        input  wr_valid, wr_ch, blank,
        output wr_ready, vm_we, vm_addr, vm_ch, cur_col, cur_row, busy
    );

    // Requester / timing / memory side.
    modport master (
        output wr_valid, wr_ch, blank,
        input  wr_ready, vm_we, vm_addr, vm_ch, cur_col, cur_row, busy
    );
endinterface

// File: rtl/vid_write_scheduler_fifo.sv
// Small synchronous FIFO with extra-bit pointers for full/empty detection.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
    assign rd_ptr_d = rd_ptr_q + (AW+1)'(pop_ok);

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage write.
    // NOTE: storage is not reset; empty pointers make stale entries unreachable,
    // and leaving it reset-free lets it map onto plain RAM/flops without a reset tree.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din_i;
        end
    end
endmodule

// File: rtl/vid_write_scheduler.sv
// Buffers requester characters, tracks the text cursor, interprets control
// codes and issues video-memory writes only during blanking.
module vid_write_scheduler
    import vid_pkg::*;
#(
    parameter int         FIFO_DEPTH = 8,
    parameter logic [7:0] CLEAR_CH   = 8'h20
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vid_write_scheduler_if.slave  bus
);
    localparam logic [COL_W-1:0] LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [VM_AW-1:0] LAST_CELL = VM_AW'(CELLS - 1);

    state_e           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [VM_AW-1:0] clr_q, clr_d;
    logic             we_q, we_d;
    logic [VM_AW-1:0] addr_q, addr_d;
    logic [7:0]       ch_q, ch_d;

    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;
    logic [ROW_W-1:0] next_row;

    assign push         = bus.wr_valid && !fifo_full;
    assign bus.wr_ready = !fifo_full;
    assign bus.busy     = !fifo_empty || (state_q == CLEAR);
    assign bus.vm_we    = we_q;
    assign bus.vm_addr  = addr_q;
    assign bus.vm_ch    = ch_q;
    assign bus.cur_col  = col_q;
    assign bus.cur_row  = row_q;

    assign next_row = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (bus.wr_ch),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Next-state: pop and decode in IDLE, fill the screen in CLEAR, only while blanking.
    // NOTE: every output of this block gets a default first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        clr_d   = clr_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        ch_d    = ch_q;
        pop     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty && bus.blank) begin
                    pop = 1'b1;
                    case (fifo_dout)
                        CH_LF: begin
                            col_d = '0;
                            row_d = next_row;
                        end
                        CH_CR: col_d = '0;
                        CH_BS: begin
                            if (col_q != '0) col_d = col_q - COL_W'(1);
                        end
                        CH_FF: begin
                            state_d = CLEAR;
                            clr_d   = '0;
                        end
                        default: begin
                            we_d   = 1'b1;
                            addr_d = cell_addr(row_q, col_q);
                            ch_d   = fifo_dout;
                            if (col_q == LAST_COL) begin
                                col_d = '0;
                                row_d = next_row;
                            end else begin
                                col_d = col_q + COL_W'(1);
                            end
                        end
                    endcase
                end
            end
            CLEAR: begin
                if (bus.blank) begin
                    we_d   = 1'b1;
                    addr_d = clr_q;
                    ch_d   = CLEAR_CH;
                    if (clr_q == LAST_CELL) begin
                        state_d = IDLE;
                        col_d   = '0;
                        row_d   = '0;
                        clr_d   = '0;
                    end else begin
                        clr_d = clr_q + VM_AW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, cursor, clear counter and registered memory-write outputs.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            clr_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            clr_q   <= clr_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            ch_q    <= ch_d;
        end
    end
endmodule

// File: tb/tb_vid_write_scheduler.sv
// Directed bench for vid_write_scheduler with a write scoreboard and cursor model.
module tb_vid_write_scheduler;

    typedef struct {
        logic [11:0] addr;
        logic [7:0]  ch;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic blank_prev = 1'b0;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_fail   = 0;
    int   n_wr     = 0;
    int   cyc      = 0;
    int   m_col    = 0;
    int   m_row    = 0;

    wr_t  sb[$];
    int   wr_cyc[$];

    vid_write_scheduler_if bus_if ();

    vid_write_scheduler #(
        .FIFO_DEPTH (8),
        .CLEAR_CH   (8'h20)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc        <= cyc + 1;
        blank_prev <= bus_if.blank;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must follow a blanking cycle and match the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && bus_if.vm_we === 1'b1) begin
            wr_t e;
            n_wr++;
            wr_cyc.push_back(cyc);
            check("we_after_blank", blank_prev, 1);
            if (sb.size() == 0) begin
                check("unexpected_write", bus_if.vm_we, 0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", bus_if.vm_addr, e.addr);
                check("wr_ch", bus_if.vm_ch, e.ch);
            end
        end
    end

    // Reference behaviour for one accepted character.
    function automatic void model_char(input logic [7:0] ch);
        case (ch)
            8'h0A: begin
                m_col = 0;
                m_row = (m_row + 1) % 30;
            end
            8'h0D: m_col = 0;
            8'h08: if (m_col > 0) m_col--;
            8'h0C: begin
                for (int i = 0; i < 2400; i++) sb.push_back('{addr: 12'(i), ch: 8'h20});
                m_col = 0;
                m_row = 0;
            end
            default: begin
                sb.push_back('{addr: 12'(m_row * 80 + m_col), ch: ch});
                m_col++;
                if (m_col == 80) begin
                    m_col = 0;
                    m_row = (m_row + 1) % 30;
                end
            end
        endcase
    endfunction

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] ch);
        bit done = 0;
        bus_if.wr_valid = 1'b1;
        bus_if.wr_ch    = ch;
        for (int i = 0; i < 20000 && !done; i++) begin
            if (bus_if.wr_ready === 1'b1) begin
                model_char(ch);
                done = 1;
            end
            step();
        end
        bus_if.wr_valid = 1'b0;
        if (!done) check("push_timeout", bus_if.wr_ready, 1);
    endtask

    task automatic drain(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            if (sb.size() == 0 && bus_if.busy === 1'b0) done = 1;
            else step();
        end
        step(2);
        if (!done) begin
            check("drain_busy", bus_if.busy, 0);
            check("drain_sb_left", sb.size(), 0);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus_if.wr_valid = 1'b0;
        bus_if.wr_ch    = 8'h00;
        sb.delete();
        wr_cyc.delete();
        m_col = 0;
        m_row = 0;
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_wr = 0;
    endtask

    task automatic check_cursor(input string tag, input int col, input int row);
        check({tag, "_col"}, bus_if.cur_col, col);
        check({tag, "_row"}, bus_if.cur_row, row);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_we"}, bus_if.vm_we, 0);
        check({tag, "_addr"}, bus_if.vm_addr, 0);
        check({tag, "_ch"}, bus_if.vm_ch, 0);
        check({tag, "_col"}, bus_if.cur_col, 0);
        check({tag, "_row"}, bus_if.cur_row, 0);
        check({tag, "_busy"}, bus_if.busy, 0);
        check({tag, "_ready"}, bus_if.wr_ready, 1);
    endtask

    initial begin
        int n_before;
        int phase;
        bit found;

        bus_if.wr_valid = 1'b0;
        bus_if.wr_ch    = 8'h00;
        bus_if.blank    = 1'b1;
        #3;
        check_idle_outputs("reset");

        // 1: two printables back to back during blanking.
        do_reset();
        push(8'h41);
        push(8'h42);
        drain(50);
        check("t1_nwr", n_wr, 2);
        if (wr_cyc.size() >= 2) check("t1_consecutive", wr_cyc[1] - wr_cyc[0], 1);
        check_cursor("t1_cursor", 2, 0);

        // 2: fill the FIFO with blanking off, then release it.
        do_reset();
        bus_if.blank = 1'b0;
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        bus_if.wr_valid = 1'b1;
        bus_if.wr_ch    = 8'h39;
        check("t2_ready_full", bus_if.wr_ready, 0);
        check("t2_busy", bus_if.busy, 1);
        step(20);
        check("t2_ready_held", bus_if.wr_ready, 0);
        check("t2_no_write", n_wr, 0);
        bus_if.blank = 1'b1;
        step();
        check("t2_ready_after_pop", bus_if.wr_ready, 1);
        model_char(8'h39);
        step();
        bus_if.wr_valid = 1'b0;
        drain(50);
        check("t2_nwr", n_wr, 9);
        check_cursor("t2_cursor", 9, 0);

        // 3: wrap at the last column, then LF and another printable.
        do_reset();
        for (int i = 0; i < 79; i++) push(8'h61 + 8'(i % 26));
        drain(200);
        check_cursor("t3_at79", 79, 0);
        push(8'h58);
        drain(20);
        check_cursor("t3_wrap", 0, 1);
        push(8'h0A);
        drain(20);
        check_cursor("t3_lf", 0, 2);
        push(8'h59);
        drain(20);
        check_cursor("t3_end", 1, 2);

        // 4: LF on the last row wraps to the top; BS at column 0 stays put.
        push(8'h0D);
        for (int i = 0; i < 27; i++) push(8'h0A);
        drain(100);
        check_cursor("t4_row29", 0, 29);
        n_before = n_wr;
        push(8'h0A);
        drain(20);
        check_cursor("t4_lf_wrap", 0, 0);
        push(8'h08);
        drain(20);
        check_cursor("t4_bs_col0", 0, 0);
        check("t4_no_write", n_wr, n_before);
        push(8'h5A);
        push(8'h08);
        drain(20);
        check_cursor("t4_bs_back", 0, 0);

        // 5: full clear with blanking 160 high / 640 low.
        do_reset();
        push(8'h0C);
        phase = 0;
        found = 0;
        for (int i = 0; i < 30000 && !found; i++) begin
            bus_if.blank = (phase < 160);
            step();
            phase = (phase + 1) % 800;
            if (bus_if.busy === 1'b0 && sb.size() == 0) found = 1;
        end
        check("t5_done", found, 1);
        bus_if.blank = 1'b1;
        step(2);
        check("t5_nwr", n_wr, 2400);
        check_cursor("t5_cursor", 0, 0);
        check("t5_busy", bus_if.busy, 0);

        // 6: asynchronous reset in the middle of a clear.
        do_reset();
        push(8'h0C);
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (bus_if.vm_we === 1'b1 && bus_if.vm_addr === 12'd1000) found = 1;
        end
        check("t6_reached_1000", found, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("t6_async");
        sb.delete();
        m_col = 0;
        m_row = 0;
        step(3);
        @(negedge clk);
        rst_n = 1'b1;
        n_wr = 0;
        step(50);
        check("t6_no_write", n_wr, 0);
        check("t6_busy", bus_if.busy, 0);
        push(8'h51);
        drain(20);
        check("t6_new_write", n_wr, 1);
        check_cursor("t6_cursor", 1, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
